glide_bank: RTL

- Multi-channel portamento (glide) engine for the synth voice path.
- Each channel's output frequency word moves toward its own target frequency word.
- Moves in linear mode (fixed step) or exponential mode (step proportional to remaining distance).
- One shared step datapath, time-multiplexed across channels: one channel per clock after each sample tick. Sits between the voice/key allocator and the oscillator phase-increment inputs.

---
 rtl/glide_pkg.sv | 17 +
 rtl/glide_step.sv | 44 ++++
 rtl/glide_bank.sv | 117 +++++++++++
 3 files changed

// File: rtl/glide_pkg.sv
// Shared types and defaults for the glide (portamento) engine.
package glide_pkg;

    localparam int GLIDE_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } glide_state_t;

    typedef enum logic {
        GLIDE_LIN = 1'b0,
        GLIDE_EXP = 1'b1
    } glide_mode_t;

endpackage

// File: rtl/glide_step.sv
// Combinational single-channel glide step: distance, step select and clamp to target.
module glide_step
    import glide_pkg::*;
#(
    parameter int WIDTH   = GLIDE_WIDTH_DEF,
    parameter int SHIFT_W = 5
) (
    input  logic [WIDTH-1:0]   cur,
    input  logic [WIDTH-1:0]   tgt,
    input  logic [WIDTH-1:0]   rate,
    input  logic               mode,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               snap,
    output logic [WIDTH-1:0]   next,
    output logic               at_target
);

    logic             rising;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] exp_step;
    logic [WIDTH-1:0] step;

    always_comb begin
        rising   = (tgt > cur);
        diff     = rising ? (tgt - cur) : (cur - tgt);
        // A shift past the word width yields zero, which the minimum step turns into 1.
        exp_step = diff >> shift;
        if (exp_step == '0) begin
            exp_step = WIDTH'(1);
        end
        step = (mode == GLIDE_EXP) ? exp_step : rate;

        // The clamp keeps the result between cur and tgt, so no wrap or overshoot.
        if (snap || (cur == tgt) || (step >= diff)) begin
            next = tgt;
        end else if (rising) begin
            next = cur + step;
        end else begin
            next = cur - step;
        end
        at_target = (next == tgt);
    end

endmodule

// File: rtl/glide_bank.sv
// Multi-channel glide engine: one shared step datapath visits one channel per clock after each tick.
//
//   state | meaning
//   IDLE  | waiting for tick; latches rate/mode/shift on tick
//   SCAN  | updating channel[idx], one channel per cycle
//   DONE  | one-cycle done pulse, then back to IDLE
module glide_bank
    import glide_pkg::*;
#(
    parameter int WIDTH    = GLIDE_WIDTH_DEF,
    parameter int CHANNELS = 4,
    parameter int SHIFT_W  = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      tick,
    input  logic [CHANNELS*WIDTH-1:0] target,
    input  logic [WIDTH-1:0]          rate,
    input  logic                      mode,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic [CHANNELS-1:0]       snap,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       settled,
    output logic                      done,
    output logic                      overrun
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    glide_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   rate_q;
    glide_mode_t        mode_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [WIDTH-1:0]   cur_q [CHANNELS];

    logic               load;
    logic               scan_en;
    logic [WIDTH-1:0]   step_next;
    logic               step_at_target;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tick) state_d = ST_SCAN;
            ST_SCAN: if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load    = (state_q == ST_IDLE) && tick;
        scan_en = (state_q == ST_SCAN);
        done    = (state_q == ST_DONE);
    end

    // Target and snap are taken live on the channel's own slot, not at tick.
    glide_step #(
        .WIDTH   (WIDTH),
        .SHIFT_W (SHIFT_W)
    ) u_step (
        .cur       (cur_q[idx_q]),
        .tgt       (target[idx_q*WIDTH +: WIDTH]),
        .rate      (rate_q),
        .mode      (mode_q),
        .shift     (shift_q),
        .snap      (snap[idx_q]),
        .next      (step_next),
        .at_target (step_at_target)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            idx_q   <= '0;
            rate_q  <= '0;
            mode_q  <= GLIDE_LIN;
            shift_q <= '0;
            settled <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cur_q[i] <= '0;
            end
        end else begin
            if (load) begin
                rate_q  <= rate;
                mode_q  <= glide_mode_t'(mode);
                shift_q <= shift;
                idx_q   <= '0;
            end
            if (scan_en) begin
                cur_q[idx_q]   <= step_next;
                settled[idx_q] <= step_at_target;
                if (idx_q != LAST_IDX) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
            if (tick && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign out[g*WIDTH +: WIDTH] = cur_q[g];
    end

endmodule
